// File: rtl/branch_pkg.sv
// Shared types for the fetch-PC redirect logic: control-transfer kinds,
// fetch-PC controller states and the default PC step.
package branch_pkg;

   typedef enum logic [1:0] {
      REDIR_NONE = 2'b00,
      REDIR_BRA  = 2'b01,
      REDIR_JAL  = 2'b10,
      REDIR_JALR = 2'b11
   } redir_type_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_FLUSH = 2'b01,
      ST_TRAP  = 2'b10
   } pc_state_e;

   localparam int INST_BYTES = 4;

endpackage

// File: rtl/pc_redirect_unit.sv
// Architectural fetch PC owner: sequential fetch over valid/ready, redirect on taken control
// transfers with a fixed-length front-end flush. Optional misaligned-target trap: MISALIGN_TRAP_EN.
module pc_redirect_unit
   import branch_pkg::*;
#(
   parameter int                   ADDR_WIDTH   = 64,
   parameter int                   INST_WIDTH   = INST_BYTES * 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int                   FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   output logic                  redirect_ready,
   input  logic [1:0]            redirect_type,
   input  logic                  bra_taken,
   input  logic [ADDR_WIDTH-1:0] bra_addr,
   input  logic [ADDR_WIDTH-1:0] jal_addr,
   input  logic [ADDR_WIDTH-1:0] jalr_addr,
   output logic [ADDR_WIDTH-1:0] fetch_pc,
   output logic                  fetch_valid,
   input  logic                  fetch_ready,
   output logic                  flush,
   output logic [1:0]            dbg_state_o
`ifdef MISALIGN_TRAP_EN
   ,
   output logic                  misalign_trap,
   output logic [ADDR_WIDTH-1:0] trap_addr,
   input  logic                  trap_ack
`endif
);

   // Handshakes: a fetch request transfers when fetch_valid & fetch_ready at a rising edge;
   // a redirect is consumed when redirect_valid & redirect_ready at a rising edge. Neither
   // valid depends combinationally on its ready.

   localparam int CW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INST_WIDTH / 8);
   localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

   pc_state_e             state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  valid_q, valid_d;
   logic                  flush_q, flush_d;
   logic                  taken;
   logic                  fire;
   logic [ADDR_WIDTH-1:0] target;

`ifdef MISALIGN_TRAP_EN
   logic                  trap_q, trap_d;
   logic [ADDR_WIDTH-1:0] trap_addr_q, trap_addr_d;
`endif

   assign fetch_pc       = pc_q;
   assign fetch_valid    = valid_q;
   assign redirect_ready = valid_q;
   assign flush          = flush_q;
   assign dbg_state_o    = state_q;

`ifdef MISALIGN_TRAP_EN
   assign misalign_trap = trap_q;
   assign trap_addr     = trap_addr_q;
`endif

   // Target select and taken decode
   always_comb begin
      taken  = 1'b0;
      target = '0;
      case (redir_type_e'(redirect_type))
         REDIR_BRA: begin
            taken  = bra_taken;
            target = bra_addr;
         end
         REDIR_JAL: begin
            taken  = 1'b1;
            target = jal_addr;
         end
         REDIR_JALR: begin
            taken  = 1'b1;
            target = jalr_addr;
         end
         default: begin
            taken  = 1'b0;
            target = '0;
         end
      endcase
`ifndef MISALIGN_TRAP_EN
      // Without the trap, low bits are dropped and the redirect proceeds normally.
      target = target & ~ADDR_WIDTH'(3);
`endif
   end

   assign fire = redirect_valid & redirect_ready & taken;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_d      = trap_q;
      trap_addr_d = trap_addr_q;
`endif
      case (state_q)
         ST_RUN: begin
            // Redirect wins over any same-cycle fetch handshake.
            if (fire) begin
               flush_d = 1'b1;
`ifdef MISALIGN_TRAP_EN
               if (target[1:0] != 2'b00) begin
                  state_d     = ST_TRAP;
                  trap_d      = 1'b1;
                  trap_addr_d = target;
               end else begin
                  pc_d    = target;
                  state_d = ST_FLUSH;
                  cnt_d   = FLUSH_LOAD;
               end
`else
               pc_d    = target;
               state_d = ST_FLUSH;
               cnt_d   = FLUSH_LOAD;
`endif
            end else if (valid_q && fetch_ready) begin
               pc_d = pc_q + STEP;
            end
         end
         ST_FLUSH: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
`ifdef MISALIGN_TRAP_EN
         ST_TRAP: begin
            if (trap_ack) begin
               pc_d    = RESET_PC;
               trap_d  = 1'b0;
               state_d = ST_FLUSH;
               cnt_d   = FLUSH_LOAD;
            end
         end
`endif
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
      valid_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         flush_q <= flush_d;
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         trap_q      <= 1'b0;
         trap_addr_q <= '0;
      end else begin
         trap_q      <= trap_d;
         trap_addr_q <= trap_addr_d;
      end
   end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed plus randomized bench for pc_redirect_unit against a cycle-level behavioural model.
// Honours MISALIGN_TRAP_EN when defined.
module tb_pc_redirect_unit;

   localparam int          AW       = 64;
   localparam logic [63:0] RST_PC   = 64'h0;
   localparam int          FLUSH_N  = 2;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [1:0]  redirect_type;
   logic        bra_taken;
   logic [63:0] bra_addr;
   logic [63:0] jal_addr;
   logic [63:0] jalr_addr;
   logic [63:0] fetch_pc;
   logic        fetch_valid;
   logic        fetch_ready;
   logic        flush;
   logic [1:0]  dbg_state;
   logic        trap_ack;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_trap;
   logic [63:0] trap_addr;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   pc_redirect_unit #(
      .ADDR_WIDTH  (AW),
      .INST_WIDTH  (32),
      .RESET_PC    (RST_PC),
      .FLUSH_CYCLES(FLUSH_N)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_valid(redirect_valid),
      .redirect_ready(redirect_ready),
      .redirect_type (redirect_type),
      .bra_taken     (bra_taken),
      .bra_addr      (bra_addr),
      .jal_addr      (jal_addr),
      .jalr_addr     (jalr_addr),
      .fetch_pc      (fetch_pc),
      .fetch_valid   (fetch_valid),
      .fetch_ready   (fetch_ready),
      .flush         (flush),
      .dbg_state_o   (dbg_state)
`ifdef MISALIGN_TRAP_EN
      ,
      .misalign_trap (misalign_trap),
      .trap_addr     (trap_addr),
      .trap_ack      (trap_ack)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: PC value, number of remaining dead fetch cycles, trap flag.
   logic [63:0] m_pc;
   int          m_stall;
   bit          m_inrst;
   bit          m_flush;
   bit          m_trap;
   logic [63:0] m_taddr;

   function automatic void model_step();
      bit          ok;
      bit          tk;
      logic [63:0] tgt;
      ok      = !m_inrst && (m_stall == 0) && !m_trap;
      m_flush = 1'b0;
      tk      = 1'b0;
      tgt     = 64'h0;
      if (redirect_type == 2'd1) begin tk = bra_taken; tgt = bra_addr; end
      if (redirect_type == 2'd2) begin tk = 1'b1; tgt = jal_addr; end
      if (redirect_type == 2'd3) begin tk = 1'b1; tgt = jalr_addr; end
      if (rst) begin
         m_pc = RST_PC; m_stall = 0; m_inrst = 1'b1; m_trap = 1'b0; m_taddr = 64'h0;
         return;
      end
      m_inrst = 1'b0;
      if (m_trap) begin
         if (trap_ack) begin
            m_trap = 1'b0; m_pc = RST_PC; m_stall = FLUSH_N;
         end
      end else if (m_stall > 0) begin
         m_stall = m_stall - 1;
      end else if (ok && redirect_valid && tk) begin
         m_flush = 1'b1;
`ifdef MISALIGN_TRAP_EN
         if (tgt[1:0] != 2'b00) begin
            m_trap = 1'b1; m_taddr = tgt;
         end else begin
            m_pc = tgt; m_stall = FLUSH_N;
         end
`else
         m_pc = tgt & ~64'h3; m_stall = FLUSH_N;
`endif
      end else if (ok && fetch_ready) begin
         m_pc = m_pc + 64'd4;
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      bit mv;
      model_step();
      @(posedge clk);
      @(negedge clk);
      mv = !m_inrst && (m_stall == 0) && !m_trap;
      chk("fetch_pc", fetch_pc, m_pc);
      chk("fetch_valid", 64'(fetch_valid), 64'(mv));
      chk("redirect_ready", 64'(redirect_ready), 64'(mv));
      chk("flush", 64'(flush), 64'(m_flush));
`ifdef MISALIGN_TRAP_EN
      chk("misalign_trap", 64'(misalign_trap), 64'(m_trap));
      chk("trap_addr", trap_addr, m_taddr);
`endif
   endtask

   task automatic idle_inputs();
      redirect_valid = 1'b0; redirect_type = 2'd0; bra_taken = 1'b0; trap_ack = 1'b0;
   endtask

   task automatic redirect(input logic [1:0] t, input logic tk, input logic [63:0] a);
      redirect_valid = 1'b1; redirect_type = t; bra_taken = tk;
      bra_addr = a; jal_addr = a; jalr_addr = a;
   endtask

   initial begin
      m_pc = 64'h0; m_stall = 0; m_inrst = 1'b1; m_flush = 1'b0; m_trap = 1'b0; m_taddr = 64'h0;
      rst = 1'b1; fetch_ready = 1'b0;
      bra_addr = '0; jal_addr = '0; jalr_addr = '0;
      idle_inputs();
      @(negedge clk);

      // 1: reset, then sequential fetch 0,4,8,C
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_valid_in_rst", 64'(fetch_valid), 64'h0);
      end
      rst = 1'b0;
      tick();
      chk("t1_pc0", fetch_pc, 64'h0);
      chk("t1_valid_after_rst", 64'(fetch_valid), 64'h1);
      fetch_ready = 1'b1;
      tick(); chk("t1_pc4", fetch_pc, 64'h4);
      tick(); chk("t1_pc8", fetch_pc, 64'h8);
      tick(); chk("t1_pcC", fetch_pc, 64'hC);
      tick(); chk("t1_pc10", fetch_pc, 64'h10);

      // 2: stall at 0x10
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_hold_pc", fetch_pc, 64'h10);
         chk("t2_hold_valid", 64'(fetch_valid), 64'h1);
      end
      fetch_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("t2_pc20", fetch_pc, 64'h20);

      // 3: not-taken branch is consumed without effect
      redirect(2'd1, 1'b0, 64'h4000);
      tick();
      chk("t3_pc24", fetch_pc, 64'h24);
      chk("t3_noflush", 64'(flush), 64'h0);
      idle_inputs();

      // 4: JAL with same-cycle handshake
      redirect(2'd2, 1'b0, 64'h1000);
      tick();
      chk("t4_flush", 64'(flush), 64'h1);
      chk("t4_valid0a", 64'(fetch_valid), 64'h0);
      idle_inputs();
      tick();
      chk("t4_flush_once", 64'(flush), 64'h0);
      chk("t4_valid0b", 64'(fetch_valid), 64'h0);
      tick();
      chk("t4_pc1000", fetch_pc, 64'h1000);
      chk("t4_valid1", 64'(fetch_valid), 64'h1);

      // 5: wrap at top of address space, then reset mid-flush
      redirect(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      idle_inputs();
      tick(); tick();
      chk("t5_pc_top", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      chk("t5_wrap", fetch_pc, 64'h0);
      redirect(2'd2, 1'b0, 64'h80);
      tick();
      idle_inputs();
      rst = 1'b1;
      tick();
      chk("t5_rst_pc", fetch_pc, RST_PC);
      chk("t5_rst_state", 64'(dbg_state), 64'h0);
      rst = 1'b0;
      tick();
      chk("t5_run_valid", 64'(fetch_valid), 64'h1);

      // 6: misaligned JALR target
      redirect(2'd3, 1'b0, 64'h1002);
      tick();
      idle_inputs();
`ifdef MISALIGN_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         chk("t6_trap", 64'(misalign_trap), 64'h1);
         chk("t6_trap_addr", trap_addr, 64'h1002);
         tick();
      end
      trap_ack = 1'b1;
      tick();
      trap_ack = 1'b0;
      chk("t6_trap_clr", 64'(misalign_trap), 64'h0);
      tick(); tick();
      chk("t6_pc_reset", fetch_pc, RST_PC);
`else
      tick(); tick();
      chk("t6_pc1000", fetch_pc, 64'h1000);
`endif

      // Randomized phase
      for (int i = 0; i < 400; i++) begin
         logic [63:0] a;
         a = {32'($urandom), 32'($urandom)} & ~64'h3;
         if ($urandom_range(0, 3) == 0) a = a | 64'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) a = 64'hFFFF_FFFF_FFFF_FFF8;
         rst            = ($urandom_range(0, 59) == 0);
         fetch_ready    = 1'($urandom_range(0, 1));
         redirect_valid = ($urandom_range(0, 3) == 0);
         redirect_type  = 2'($urandom_range(0, 3));
         bra_taken      = 1'($urandom_range(0, 1));
         bra_addr       = a;
         jal_addr       = a ^ 64'h100;
         jalr_addr      = a ^ 64'h200;
         trap_ack       = ($urandom_range(0, 3) == 0);
         tick();
      end
      rst = 1'b0;
      idle_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
